// File: rtl/mx2_pkg.sv
// Shared constants for the mx2 selector family.
// Width limit and register reset value used by every mx2 module.
package mx2_pkg;

    localparam int MX2_MAX_WIDTH = 64;

    localparam logic [MX2_MAX_WIDTH-1:0] MX2_RST_VAL = '0;

endpackage

// File: rtl/mx2_if.sv
// Signal bundle for one 2:1 selection channel.
// A master drives the data and select; a slave returns the selected value.
interface mx2_if
    import mx2_pkg::*;
#(
    parameter int WIDTH = 1
);

    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             s;
    logic [WIDTH-1:0] y;

    modport master (
        output d0,
        output d1,
        output s,
        input  y
    );

    modport slave (
        input  d0,
        input  d1,
        input  s,
        output y
    );

endinterface

// File: rtl/mx2_comb.sv
// Combinational WIDTH-bit 2:1 selector.
// The ?: operator keeps the standard behaviour for an unknown select.
module mx2_comb #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    // With an unknown select, bits where d0 and d1 agree keep that common value.
    assign y = s ? d1 : d0;

endmodule

// File: rtl/mx2_sync.sv
// 2:1 selector with an optional output register.
// Port order d0, d1, s, y, clk, rst keeps older positional instances valid.
module mx2_sync
    import mx2_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y,
    input  logic             clk,
    input  logic             rst
);

    logic [WIDTH-1:0] sel;

    if (WIDTH < 1 || WIDTH > MX2_MAX_WIDTH) begin : g_bad_width
        $fatal(1, "mx2_sync: WIDTH=%0d outside 1..%0d", WIDTH, MX2_MAX_WIDTH);
    end

    mx2_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .d0 (d0),
        .d1 (d1),
        .s  (s),
        .y  (sel)
    );

    if (REG_OUT) begin : g_reg
        // NOTE: non-blocking assignment so every register samples the pre-edge values.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                y <= MX2_RST_VAL[WIDTH-1:0];
            end else begin
                y <= sel;
            end
        end
    end else begin : g_comb
        logic unused_clk_rst;

        assign unused_clk_rst = clk | rst;
        assign y              = sel;
    end

endmodule

// File: tb/tb_mx2_sync.sv
// Directed bench for mx2_sync: combinational and registered builds at WIDTH 1,
// plus a registered WIDTH 8 build, all sharing one clock and reset.
module tb_mx2_sync;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_pass   = 0;

    mx2_if #(.WIDTH(1)) bus_c ();
    mx2_if #(.WIDTH(1)) bus_r ();
    mx2_if #(.WIDTH(8)) bus_w ();

    mx2_sync #(.WIDTH(1), .REG_OUT(1'b0)) u_dut_c (
        .d0  (bus_c.d0),
        .d1  (bus_c.d1),
        .s   (bus_c.s),
        .y   (bus_c.y),
        .clk (clk),
        .rst (rst)
    );

    mx2_sync #(.WIDTH(1), .REG_OUT(1'b1)) u_dut_r (
        .d0  (bus_r.d0),
        .d1  (bus_r.d1),
        .s   (bus_r.s),
        .y   (bus_r.y),
        .clk (clk),
        .rst (rst)
    );

    mx2_sync #(.WIDTH(8), .REG_OUT(1'b1)) u_dut_w (
        .d0  (bus_w.d0),
        .d1  (bus_w.d1),
        .s   (bus_w.s),
        .y   (bus_w.y),
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive1(input logic s_v, input logic d0_v, input logic d1_v);
        bus_c.s  = s_v;
        bus_c.d0 = d0_v;
        bus_c.d1 = d1_v;
        bus_r.s  = s_v;
        bus_r.d0 = d0_v;
        bus_r.d1 = d1_v;
    endtask

    // Rows are {s, d0, d1}; y_tab holds the hand-derived selection for each row.
    logic [2:0] row;
    logic [7:0] y_tab;
    logic       y_prev;
    logic [7:0] w_exp;

    initial begin
        y_tab = 8'b1010_1100;
        rst   = 1'b1;
        drive1(1'b0, 1'b0, 1'b0);
        bus_w.s  = 1'b0;
        bus_w.d0 = 8'h00;
        bus_w.d1 = 8'h00;

        #1;
        check("reset_y_r", {63'd0, bus_r.y}, 64'd0);
        check("reset_y_w", {56'd0, bus_w.y}, 64'd0);
        @(posedge clk);
        #1;
        check("reset_hold_r", {63'd0, bus_r.y}, 64'd0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        y_prev = 1'b0;

        // Truth table: comb output immediate, registered output one edge later.
        for (int i = 0; i < 8; i++) begin
            row = 3'(i);
            @(negedge clk);
            drive1(row[2], row[1], row[0]);
            #1;
            check($sformatf("tt_comb_%0d", i), {63'd0, bus_c.y}, {63'd0, y_tab[i]});
            check($sformatf("tt_hold_%0d", i), {63'd0, bus_r.y}, {63'd0, y_prev});
            @(posedge clk);
            #1;
            check($sformatf("tt_reg_%0d", i), {63'd0, bus_r.y}, {63'd0, y_tab[i]});
            y_prev = y_tab[i];
        end

        // Mid-cycle asynchronous reset.
        @(negedge clk);
        drive1(1'b1, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_y", {63'd0, bus_r.y}, 64'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_y", {63'd0, bus_r.y}, 64'd0);
        @(posedge clk);
        #1;
        check("rst_held_y", {63'd0, bus_r.y}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_y", {63'd0, bus_r.y}, 64'd0);
        @(posedge clk);
        #1;
        check("post_rst_y", {63'd0, bus_r.y}, 64'd1);

        // WIDTH 8 selection and alternating select with one-cycle lag.
        @(negedge clk);
        bus_w.d0 = 8'hA5;
        bus_w.d1 = 8'h5A;
        bus_w.s  = 1'b0;
        @(posedge clk);
        #1;
        check("w8_s0", {56'd0, bus_w.y}, 64'h00A5);
        @(negedge clk);
        bus_w.s = 1'b1;
        @(posedge clk);
        #1;
        check("w8_s1", {56'd0, bus_w.y}, 64'h005A);
        w_exp = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_w.s = ~bus_w.s;
            #1;
            check($sformatf("w8_lag_%0d", i), {56'd0, bus_w.y}, {56'd0, w_exp});
            w_exp = (w_exp == 8'h5A) ? 8'hA5 : 8'h5A;
            @(posedge clk);
            #1;
            check($sformatf("w8_tog_%0d", i), {56'd0, bus_w.y}, {56'd0, w_exp});
        end

        // Reset asserted on the same edge that the select rises.
        @(negedge clk);
        drive1(1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check("coin_pre_y", {63'd0, bus_r.y}, 64'd1);
        @(negedge clk);
        bus_r.d0 = 1'b0;
        @(posedge clk);
        rst     = 1'b1;
        bus_r.s = 1'b1;
        #1;
        check("coin_rst_y", {63'd0, bus_r.y}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("coin_post_y", {63'd0, bus_r.y}, 64'd1);

        // Unknown select with equal data inputs still yields the common value.
        @(negedge clk);
        bus_c.d0 = 1'b1;
        bus_c.d1 = 1'b1;
        bus_c.s  = 1'bx;
        #1;
        check("selx_equal_y", {63'd0, bus_c.y}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
